// File: rtl/accel_driver_if.sv
// accel_driver_if: push, engine and result handshake bundle for accel_driver.
// master = the driver itself; slave = the host/engine side that talks to it.
interface accel_driver_if;
  logic        push_valid_i;
  logic [7:0]  push_a_i;
  logic [7:0]  push_b_i;
  logic        push_ready_o;
  logic        eng_start_o;
  logic [7:0]  eng_a_o;
  logic [7:0]  eng_b_o;
  logic        eng_busy_i;
  logic [15:0] eng_y_i;
  logic        res_valid_o;
  logic [15:0] res_y_o;
  logic        res_ready_i;

  modport master (
    input  push_valid_i, push_a_i, push_b_i, eng_busy_i, eng_y_i, res_ready_i,
    output push_ready_o, eng_start_o, eng_a_o, eng_b_o, res_valid_o, res_y_o
  );

  modport slave (
    output push_valid_i, push_a_i, push_b_i, eng_busy_i, eng_y_i, res_ready_i,
    input  push_ready_o, eng_start_o, eng_a_o, eng_b_o, res_valid_o, res_y_o
  );
endinterface

// File: rtl/accel_driver.sv
// accel_driver: host-side initiator for a start/busy arithmetic engine.
// Operand pairs are queued in a small FIFO, issued one at a time, and each
// engine result is returned on a valid/ready result port.
// Optional: define ACCEL_DRIVER_CHECK_EN to compare every engine result with
// a built-in golden model; a disagreement sets the sticky chk_err_o.
module accel_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  accel_driver_if.master              bus,
  output logic                        to_err_o,
  output logic                        chk_err_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ACK, RUN, STORE} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       eng_a_q, eng_a_d;
  logic [7:0]       eng_b_q, eng_b_d;
  logic             start_q, start_d;
  logic             res_valid_q, res_valid_d;
  logic [15:0]      res_y_q, res_y_d;
  logic [15:0]      hold_q, hold_d;
  logic             to_err_q, to_err_d;
  logic [15:0]      mem_q [FIFO_DEPTH];
  logic             push_ready;
  logic             push_fire;
  logic             pop;

  // Ready comes from the registered level, so a push into a full FIFO is
  // refused even when the same cycle pops.
  assign push_ready = (level_q != LVL_W'(FIFO_DEPTH));
  assign push_fire  = bus.push_valid_i && push_ready;

  // Next-state, FIFO bookkeeping and result-port logic
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    eng_a_d     = eng_a_q;
    eng_b_d     = eng_b_q;
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    hold_d      = hold_q;
    to_err_d    = to_err_q;
    pop         = 1'b0;

    if (res_valid_q && bus.res_ready_i) res_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Never start into a busy engine (also covers engine held in reset).
        if (level_q != '0 && !bus.eng_busy_i) begin
          pop     = 1'b1;
          eng_a_d = mem_q[rd_ptr_q][15:8];
          eng_b_d = mem_q[rd_ptr_q][7:0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = ACK;
      end
      ACK: begin
        if (bus.eng_busy_i) begin
          state_d = RUN;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RUN: begin
        if (!bus.eng_busy_i) begin
          hold_d  = bus.eng_y_i;
          state_d = STORE;
        end
      end
      STORE: begin
        if (!res_valid_q || bus.res_ready_i) begin
          res_y_d     = hold_q;
          res_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)       rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push_fire) - LVL_W'(pop);
    start_d = (state_d == ISSUE);
  end

  // Control and output registers; reset discards every queued or in-flight command
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      eng_a_q     <= eng_a_d;
      eng_b_q     <= eng_b_d;
      start_q     <= start_d;
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      to_err_q    <= to_err_d;
    end
  end

  // FIFO storage and result hold register carry data only, so no reset
  always_ff @(posedge clk_i) begin
    if (push_fire) mem_q[wr_ptr_q] <= {bus.push_a_i, bus.push_b_i};
    hold_q <= hold_d;
  end

`ifdef ACCEL_DRIVER_CHECK_EN
  // Golden model: {8'b0, (2*(b^3 mod 256)) mod 256} + 3*a
  function automatic logic [15:0] golden(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] cube;
    logic [7:0] dbl;
    cube   = 8'(b * b * b);
    dbl    = 8'({cube, 1'b0});
    golden = {8'b0, dbl} + 16'(a) * 16'd3;
  endfunction

  logic chk_err_q, chk_err_d;

  // Flag (sticky) any completed result that disagrees with the golden model
  always_comb begin
    chk_err_d = chk_err_q;
    if (state_q == RUN && !bus.eng_busy_i && bus.eng_y_i != golden(eng_a_q, eng_b_q))
      chk_err_d = 1'b1;
  end

  // Sticky check flag, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) chk_err_q <= 1'b0;
    else       chk_err_q <= chk_err_d;
  end

  assign chk_err_o = chk_err_q;
`else
  assign chk_err_o = 1'b0;
`endif

  assign bus.push_ready_o = push_ready;
  assign bus.eng_start_o  = start_q;
  assign bus.eng_a_o      = eng_a_q;
  assign bus.eng_b_o      = eng_b_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_y_o      = res_y_q;
  assign to_err_o         = to_err_q;
  assign fifo_level_o     = level_q;
endmodule
